// File: rtl/mem_responder.sv
// Single-port memory responder: valid/ready request in, held response out.
// Define MEM_RESP_WAIT_EN to add a WAIT-cycle delay between accept and access.
module mem_responder #(
    parameter int ADDR_BITS = 7,
    parameter int WAIT      = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int WIDX  = ADDR_BITS - 2;
    localparam int WORDS = 2 ** WIDX;

`ifdef MEM_RESP_WAIT_EN
    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_WAIT = 2'd1, ST_RESP = 2'd2} state_t;
    localparam int CNT_W = (WAIT > 1) ? $clog2(WAIT) : 1;
    logic [CNT_W-1:0] cnt_q, cnt_d;
`else
    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RESP = 2'd2} state_t;
    logic unused_wait;
    assign unused_wait = (WAIT != 0);
`endif

    state_t               state_q, state_d;
    logic                 we_q, we_d;
    logic [ADDR_BITS-1:0] addr_q, addr_d;
    logic [31:0]          wdata_q, wdata_d;
    logic [1:0]           size_q, size_d;
    logic                 uns_q, uns_d;
    logic                 err_q, err_d;
    logic [31:0]          rdata_q, rdata_d;
    logic                 resp_err_q, resp_err_d;
    logic [31:0]          mem_q [WORDS];

    logic                 req_fault;
    logic                 in_idle;
    logic                 acc_we, acc_uns, acc_err;
    logic [ADDR_BITS-1:0] acc_addr;
    logic [31:0]          acc_wdata;
    logic [1:0]           acc_size;
    logic [31:0]          acc_word, acc_lane, acc_load, wr_mask, wr_data;
    logic                 do_access, mem_we;

    assign req_fault = (req_size == 2'd3)
                     || ((req_size == 2'd1) && req_addr[0])
                     || ((req_size == 2'd2) && (req_addr[1:0] != 2'b00))
                     || (req_addr[31:ADDR_BITS] != '0);

    // An access from IDLE happens on the accept edge, so it uses the live request.
    assign in_idle   = (state_q == ST_IDLE);
    assign acc_we    = in_idle ? req_we                    : we_q;
    assign acc_addr  = in_idle ? req_addr[ADDR_BITS-1:0]   : addr_q;
    assign acc_wdata = in_idle ? req_wdata                 : wdata_q;
    assign acc_size  = in_idle ? req_size                  : size_q;
    assign acc_uns   = in_idle ? req_unsigned              : uns_q;
    assign acc_err   = in_idle ? req_fault                 : err_q;

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        acc_word = mem_q[acc_addr[ADDR_BITS-1:2]];
        acc_lane = acc_word >> {acc_addr[1:0], 3'b000};
        wr_data  = acc_wdata << {acc_addr[1:0], 3'b000};
        acc_load = '0;
        wr_mask  = '0;
        case (acc_size)
            2'd0: begin
                acc_load = {{24{~acc_uns & acc_lane[7]}}, acc_lane[7:0]};
                wr_mask  = 32'h0000_00ff << {acc_addr[1:0], 3'b000};
            end
            2'd1: begin
                acc_load = {{16{~acc_uns & acc_lane[15]}}, acc_lane[15:0]};
                wr_mask  = 32'h0000_ffff << {acc_addr[1:0], 3'b000};
            end
            2'd2: begin
                acc_load = acc_word;
                wr_mask  = 32'hffff_ffff;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        size_d     = size_q;
        uns_d      = uns_q;
        err_d      = err_q;
        rdata_d    = rdata_q;
        resp_err_d = resp_err_q;
        do_access  = 1'b0;
`ifdef MEM_RESP_WAIT_EN
        cnt_d      = cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    addr_d  = req_addr[ADDR_BITS-1:0];
                    wdata_d = req_wdata;
                    size_d  = req_size;
                    uns_d   = req_unsigned;
                    err_d   = req_fault;
`ifdef MEM_RESP_WAIT_EN
                    cnt_d   = CNT_W'(WAIT - 1);
                    if (WAIT == 0) begin
                        do_access = 1'b1;
                        state_d   = ST_RESP;
                    end else begin
                        state_d   = ST_WAIT;
                    end
`else
                    do_access = 1'b1;
                    state_d   = ST_RESP;
`endif
                end
            end
`ifdef MEM_RESP_WAIT_EN
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    do_access = 1'b1;
                    state_d   = ST_RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
`endif
            ST_RESP: begin
                if (resp_ready) begin
                    state_d    = ST_IDLE;
                    rdata_d    = '0;
                    resp_err_d = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (do_access) begin
            rdata_d    = (acc_we || acc_err) ? 32'h0 : acc_load;
            resp_err_d = acc_err;
        end
    end

    assign mem_we = do_access && acc_we && !acc_err;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            size_q     <= '0;
            uns_q      <= 1'b0;
            err_q      <= 1'b0;
            rdata_q    <= '0;
            resp_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            size_q     <= size_d;
            uns_q      <= uns_d;
            err_q      <= err_d;
            rdata_q    <= rdata_d;
            resp_err_q <= resp_err_d;
        end
    end

`ifdef MEM_RESP_WAIT_EN
    always_ff @(posedge clk) begin
        if (!rst) cnt_q <= '0;
        else      cnt_q <= cnt_d;
    end
`endif

    // NOTE: storage has no reset; contents survive rst, and a write pending at reset is dropped.
    always_ff @(posedge clk) begin
        if (rst && mem_we) begin
            mem_q[acc_addr[ADDR_BITS-1:2]] <= (mem_q[acc_addr[ADDR_BITS-1:2]] & ~wr_mask)
                                            | (wr_data & wr_mask);
        end
    end

    assign req_ready  = rst && (state_q == ST_IDLE);
    assign resp_valid = (state_q == ST_RESP);
    assign resp_rdata = rdata_q;
    assign resp_err   = resp_err_q;

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter ADDR_BITS, default 7, SHALL set the byte-address width of storage (2^ADDR_BITS bytes, word-organised).
REQ-002 Parameter WAIT, default 2, SHALL set the number of wait cycles between request acceptance and response.
REQ-003 Ports SHALL be as listed below.
- clk  in  1  sole clock; all state updates on posedge.
- rst  in  1  synchronous, active-low reset.
- req_valid  in  1  initiator presents a request.
- req_ready  out  1  responder can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned.
- req_size  in  2  0 = byte, 1 = half, 2 = word; 3 is illegal.
- req_unsigned  in  1  1 = zero-extend load, 0 = sign-extend.
- resp_valid  out  1  response is present.
- resp_ready  in  1  initiator accepts the response.
- resp_rdata  out  32  extended load data; 0 for stores and errors.
- resp_err  out  1  request faulted.

Function
REQ-004 FSM states SHALL be IDLE, WAIT and RESP; req_ready SHALL be 1 only in IDLE, and resp_valid SHALL be 1 only in RESP.
REQ-005 In IDLE with req_valid=1, the block SHALL latch all req_* fields and move to WAIT with the counter at WAIT-1. If WAIT=0, it SHALL go directly to RESP.
REQ-006 In WAIT, the counter SHALL decrement each cycle. At count 0 the block SHALL perform the access and enter RESP on the next edge.
- Latency from accept edge to first resp_valid cycle = WAIT+1 cycles.
REQ-007 In RESP, resp_valid, resp_rdata and resp_err SHALL be held stable until resp_ready=1. On that edge the block SHALL return to IDLE; there is no back-to-back accept on that same edge.
REQ-008 An error SHALL be flagged for any of:
- req_size=3;
- half access with addr[0]=1;
- word access with addr[1:0]!=0;
- addr >= 2^ADDR_BITS.
REQ-009 On error: no storage write, resp_rdata=0, resp_err=1.
REQ-010 Stores SHALL write only the addressed byte lanes (little-endian), taking the low 8/16/32 bits of wdata. The write SHALL commit exactly once, on the WAIT->RESP edge.
REQ-011 Loads SHALL select the addressed lanes and sign- or zero-extend them to 32 bits per req_unsigned. The value SHALL be captured on the WAIT->RESP edge.
REQ-012 While not in IDLE, req_* input changes SHALL have no effect.

Reset
REQ-013 With rst=0 at a posedge, the block SHALL enter IDLE, clear the counter, and drive req_ready=1 (after reset release), resp_valid=0, resp_rdata=0, resp_err=0.
REQ-014 Reset while in WAIT SHALL drop the pending store uncommitted. Reset while in RESP SHALL discard the response.
REQ-015 Storage contents SHALL NOT be cleared by reset.
REQ-016 While rst=0, req_ready SHALL be driven 0.

Configuration
REQ-017 Macro MEM_RESP_WAIT_EN:
- Defined: WAIT state and counter are present; behaviour per REQ-005/006.
- Undefined: the WAIT parameter is ignored, the WAIT state and counter are removed, the access occurs on the accept edge, and resp_valid rises in the next cycle (latency 1).

Verification
REQ-018 Store word 0xDEADBEEF at 0x10, then load word 0x10 with WAIT=2 -> resp_valid 3 cycles after each accept; rdata=0xDEADBEEF, err=0.
REQ-019 Store byte 0x80 at 0x11, then load byte signed at 0x11 -> rdata=0xFFFFFF80. Load byte unsigned -> 0x00000080. Load word 0x10 -> 0xDEAD80EF.
REQ-020 Load half at 0x13, load word at 0x12, load size=3, and store at 0x80 (ADDR_BITS=7) -> each err=1, rdata=0, and memory is unchanged on readback.
REQ-021 Hold resp_ready=0 for 5 cycles in RESP -> resp_* stay stable and req_ready stays 0. Raise resp_ready -> IDLE next cycle with req_ready=1.
REQ-022 Assert rst=0 during WAIT of a store of 0x12345678 to 0x20 -> all outputs reset next edge; a later load of 0x20 returns the prior value.
REQ-023 Build without MEM_RESP_WAIT_EN -> the load response appears 1 cycle after accept, with data identical to REQ-018.
